// File: rtl/decode_issue_stage_if.sv
// Decode/issue stage bus: instruction handshake, write-back port and execute-stage outputs.
interface decode_issue_stage_if #(
  parameter int N = 32,
  parameter int C = 7,
  parameter int S = 5
);
  logic [N-1:0] instr;
  logic         instr_valid;
  logic         instr_ready;
  logic         ex_stall;
  logic         wb_en;
  logic [S-1:0] wb_addr;
  logic [N-1:0] wb_data;
  logic         enable_ex;
  logic [N-1:0] src1;
  logic [N-1:0] src2;
  logic [N-1:0] imm;
  logic [C-1:0] control_in;
  logic [S-1:0] rd_out;
  logic         illegal_instr;

  modport slave (
    input  instr, instr_valid, ex_stall, wb_en, wb_addr, wb_data,
    output instr_ready, enable_ex, src1, src2, imm, control_in, rd_out, illegal_instr
  );

  modport master (
    output instr, instr_valid, ex_stall, wb_en, wb_addr, wb_data,
    input  instr_ready, enable_ex, src1, src2, imm, control_in, rd_out, illegal_instr
  );
endinterface

// File: rtl/decode_issue_stage.sv
// RV32I-subset decode/issue stage: register file with write bypass, decode to the
// execute-stage control word, load-use bubble insertion and stall hold.
module decode_issue_stage #(
  parameter int N    = 32,
  parameter int C    = 7,
  parameter int S    = 5,
  parameter int REGS = 32
) (
  input logic                 clock,
  input logic                 reset,
  decode_issue_stage_if.slave dec_if
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [2:0] CL_R   = 3'b000;
  localparam logic [2:0] CL_I   = 3'b001;
  localparam logic [2:0] CL_LD  = 3'b010;
  localparam logic [2:0] CL_ST  = 3'b011;
  localparam logic [2:0] CL_LUI = 3'b100;

  logic [N-1:0] rf_q [REGS];

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [S-1:0] rs1_f, rs2_f, rd_f;

  logic         dec_legal, dec_use_rs1, dec_use_rs2;
  logic [2:0]   dec_cls;
  logic [3:0]   dec_func;
  logic [N-1:0] dec_imm;
  logic [S-1:0] dec_rd;
  logic [N-1:0] rs1_val, rs2_val;

  logic         enable_q, enable_d;
  logic [N-1:0] src1_q, src1_d, src2_q, src2_d, imm_q, imm_d;
  logic [C-1:0] control_q, control_d;
  logic [S-1:0] rd_q, rd_d;
  logic         illegal_q, illegal_d;
  logic         hazard, accept;

  assign opcode = dec_if.instr[6:0];
  assign funct3 = dec_if.instr[14:12];
  assign funct7 = dec_if.instr[31:25];
  assign rs1_f  = dec_if.instr[19:15];
  assign rs2_f  = dec_if.instr[24:20];
  assign rd_f   = dec_if.instr[11:7];

  always_comb begin
    dec_legal   = 1'b0;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_cls     = CL_R;
    dec_func    = 4'b0000;
    dec_imm     = '0;
    dec_rd      = rd_f;
    case (opcode)
      OP_R: begin
        dec_legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_func    = {dec_if.instr[30], funct3};
      end
      OP_I: begin
        dec_legal   = 1'b1;
        dec_use_rs1 = 1'b1;
        dec_cls     = CL_I;
        // Only the shifts carry a meaningful instr[30] (SRLI vs SRAI)
        dec_func    = (funct3 == 3'b001 || funct3 == 3'b101) ? {dec_if.instr[30], funct3}
                                                             : {1'b0, funct3};
        dec_imm     = {{(N-12){dec_if.instr[31]}}, dec_if.instr[31:20]};
      end
      OP_LD: begin
        dec_legal   = (funct3 == 3'b010);
        dec_use_rs1 = 1'b1;
        dec_cls     = CL_LD;
        dec_imm     = {{(N-12){dec_if.instr[31]}}, dec_if.instr[31:20]};
      end
      OP_ST: begin
        dec_legal   = (funct3 == 3'b010);
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_cls     = CL_ST;
        dec_imm     = {{(N-12){dec_if.instr[31]}}, dec_if.instr[31:25], dec_if.instr[11:7]};
        dec_rd      = '0;
      end
      OP_LUI: begin
        dec_legal = 1'b1;
        dec_cls   = CL_LUI;
        dec_imm   = {dec_if.instr[N-1:12], 12'b0};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Same-cycle write-back wins over the stored value; x0 always reads zero
  always_comb begin
    rs1_val = rf_q[rs1_f];
    rs2_val = rf_q[rs2_f];
    if (dec_if.wb_en && dec_if.wb_addr == rs1_f) rs1_val = dec_if.wb_data;
    if (dec_if.wb_en && dec_if.wb_addr == rs2_f) rs2_val = dec_if.wb_data;
    if (rs1_f == '0) rs1_val = '0;
    if (rs2_f == '0) rs2_val = '0;
  end

  assign hazard = enable_q && (control_q[C-1 -: 3] == CL_LD) && (rd_q != '0) &&
                  dec_if.instr_valid && dec_legal &&
                  ((dec_use_rs1 && rs1_f == rd_q) || (dec_use_rs2 && rs2_f == rd_q));
  assign dec_if.instr_ready = reset && !dec_if.ex_stall && !hazard;
  assign accept = dec_if.instr_valid && dec_if.instr_ready;

  always_comb begin
    enable_d  = enable_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    imm_d     = imm_q;
    control_d = control_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    if (dec_if.ex_stall) begin
      illegal_d = 1'b0;
    end else if (accept && dec_legal) begin
      enable_d  = 1'b1;
      src1_d    = dec_use_rs1 ? rs1_val : '0;
      src2_d    = dec_use_rs2 ? rs2_val : '0;
      imm_d     = dec_imm;
      control_d = {dec_cls, dec_func};
      rd_d      = dec_rd;
      illegal_d = 1'b0;
    end else begin
      // Bubble; an accepted undecodable word also flags illegal for one cycle
      enable_d  = 1'b0;
      control_d = '0;
      illegal_d = accept;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      enable_q  <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      control_q <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      imm_q     <= imm_d;
      control_q <= control_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clock) begin
    if (dec_if.wb_en && dec_if.wb_addr != '0) begin
      rf_q[dec_if.wb_addr] <= dec_if.wb_data;
    end
  end

  assign dec_if.enable_ex     = enable_q;
  assign dec_if.src1          = src1_q;
  assign dec_if.src2          = src2_q;
  assign dec_if.imm           = imm_q;
  assign dec_if.control_in    = control_q;
  assign dec_if.rd_out        = rd_q;
  assign dec_if.illegal_instr = illegal_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench: directed test-plan sequence with literal checks, then random
// traffic compared every cycle against a behavioural model of the issue stage.
module tb_decode_issue_stage;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  decode_issue_stage_if dif ();

  decode_issue_stage dut (
    .clock (clk),
    .reset (rst_n),
    .dec_if(dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        legal;
    bit [2:0]  cls;
    bit [3:0]  fn;
    bit [31:0] imm;
    bit        u1;
    bit        u2;
    bit [4:0]  rd;
  } dec_t;

  // Model state: architectural registers and the expected output register contents
  logic [31:0] regs [32];
  logic        m_en, m_ill;
  logic [31:0] m_src1, m_src2, m_imm;
  logic [6:0]  m_ctl;
  logic [4:0]  m_rd;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    m_en = 0; m_ill = 0; m_src1 = 0; m_src2 = 0; m_imm = 0; m_ctl = 0; m_rd = 0;
  end

  function automatic int sext(input int v, input int bits);
    int r;
    r = v;
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return r;
  endfunction

  function automatic dec_t model_decode(input logic [31:0] w);
    dec_t d;
    int   f3;
    f3 = int'(w[14:12]);
    d.legal = 0; d.cls = 0; d.fn = 0; d.imm = 0; d.u1 = 0; d.u2 = 0; d.rd = w[11:7];
    case (w[6:0])
      7'h33: if (w[31:25] == 7'h00 || w[31:25] == 7'h20) begin
        d.legal = 1; d.cls = 0; d.u1 = 1; d.u2 = 1;
        d.fn = 4'(f3 + (w[30] ? 8 : 0));
      end
      7'h13: begin
        d.legal = 1; d.cls = 1; d.u1 = 1;
        d.fn = (f3 == 1 || f3 == 5) ? 4'(f3 + (w[30] ? 8 : 0)) : 4'(f3);
        d.imm = 32'(sext(int'(w[31:20]), 12));
      end
      7'h03: if (f3 == 2) begin
        d.legal = 1; d.cls = 2; d.u1 = 1;
        d.imm = 32'(sext(int'(w[31:20]), 12));
      end
      7'h23: if (f3 == 2) begin
        d.legal = 1; d.cls = 3; d.u1 = 1; d.u2 = 1; d.rd = 0;
        d.imm = 32'(sext(int'(w[31:25]) * 32 + int'(w[11:7]), 12));
      end
      7'h37: begin
        d.legal = 1; d.cls = 4;
        d.imm = w & 32'hFFFFF000;
      end
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (dif.wb_en && dif.wb_addr == r) return dif.wb_data;
    return regs[r];
  endfunction

  function automatic bit model_ready();
    dec_t d;
    bit   hz;
    d  = model_decode(dif.instr);
    hz = m_en && (m_ctl[6:4] == 3'd2) && (m_rd != 0) && dif.instr_valid && d.legal &&
         ((d.u1 && dif.instr[19:15] == m_rd) || (d.u2 && dif.instr[24:20] == m_rd));
    return rst_n && !dif.ex_stall && !hz;
  endfunction

  always @(posedge clk) begin
    dec_t d;
    bit   rdy;
    rdy = model_ready();
    d   = model_decode(dif.instr);
    if (!rst_n) begin
      m_en = 0; m_ill = 0; m_src1 = 0; m_src2 = 0; m_imm = 0; m_ctl = 0; m_rd = 0;
    end else if (dif.ex_stall) begin
      m_ill = 0;
    end else if (dif.instr_valid && rdy) begin
      if (d.legal) begin
        m_en   = 1;
        m_ctl  = {d.cls, d.fn};
        m_src1 = d.u1 ? model_read(dif.instr[19:15]) : 32'h0;
        m_src2 = d.u2 ? model_read(dif.instr[24:20]) : 32'h0;
        m_imm  = d.imm;
        m_rd   = d.rd;
        m_ill  = 0;
      end else begin
        m_en = 0; m_ctl = 0; m_ill = 1;
      end
    end else begin
      m_en = 0; m_ctl = 0; m_ill = 0;
    end
    if (dif.wb_en && dif.wb_addr != 0) regs[dif.wb_addr] = dif.wb_data;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  bit run_cmp = 1;
  always @(negedge clk) begin
    if (run_cmp) begin
      cmp("enable_ex", 32'(dif.enable_ex), 32'(m_en));
      cmp("src1", dif.src1, m_src1);
      cmp("src2", dif.src2, m_src2);
      cmp("imm", dif.imm, m_imm);
      cmp("control_in", 32'(dif.control_in), 32'(m_ctl));
      cmp("rd_out", 32'(dif.rd_out), 32'(m_rd));
      cmp("illegal_instr", 32'(dif.illegal_instr), 32'(m_ill));
      cmp("instr_ready", 32'(dif.instr_ready), 32'(model_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [31:0] ins, input bit v, input bit st,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd);
    dif.instr = ins; dif.instr_valid = v; dif.ex_stall = st;
    dif.wb_en = we; dif.wb_addr = wa; dif.wb_data = wd;
  endtask

  task automatic chk_ready(input string nm, input bit exp);
    #1;
    cmp(nm, 32'(dif.instr_ready), 32'(exp));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    logic [6:0] f7;
    int         k;
    k   = $urandom_range(0, 9);
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    f7  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
    case (k)
      0, 1: return {f7, rs2, rs1, f3, rd, 7'h33};
      2, 3: return {12'($urandom), rs1, f3, rd, 7'h13};
      4:    return {12'($urandom), rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd2, rd, 7'h03};
      5:    return {7'($urandom), rs2, rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd2, 5'($urandom), 7'h23};
      6:    return {20'($urandom), rd, 7'h37};
      7:    return $urandom;
      default: return {12'($urandom), rs1, 3'd2, rd, 7'h03};
    endcase
  endfunction

  localparam logic [31:0] ADD3  = 32'h002081B3;
  localparam logic [31:0] ADDI5 = 32'hFFA00293;
  localparam logic [31:0] LW6   = 32'h0080A303;
  localparam logic [31:0] ADD7  = 32'h002303B3;
  localparam logic [31:0] ADD9  = 32'h000004B3;

  initial begin
    rst_n = 1'b0;
    set_in(32'h0, 0, 0, 0, 5'd0, 32'h0);
    tick(); tick();
    cmp("reset_enable_ex", 32'(dif.enable_ex), 32'h0);
    cmp("reset_ready", 32'(dif.instr_ready), 32'h0);
    rst_n = 1'b1;
    for (int r = 1; r < 32; r++) begin
      set_in(32'h0, 0, 0, 1, 5'(r), $urandom);
      tick();
    end

    // ADD x3,x1,x2
    set_in(32'h0, 0, 0, 1, 5'd1, 32'd4); tick();
    set_in(32'h0, 0, 0, 1, 5'd2, 32'd9); tick();
    set_in(ADD3, 1, 0, 0, 5'd0, 32'h0);
    chk_ready("add_ready", 1);
    tick();
    cmp("add_en", 32'(dif.enable_ex), 32'h1);
    cmp("add_src1", dif.src1, 32'd4);
    cmp("add_src2", dif.src2, 32'd9);
    cmp("add_imm", dif.imm, 32'h0);
    cmp("add_ctl", 32'(dif.control_in), 32'h00);
    cmp("add_rd", 32'(dif.rd_out), 32'd3);

    // ADDI x5,x0,-6
    set_in(ADDI5, 1, 0, 0, 5'd0, 32'h0); tick();
    cmp("addi_src1", dif.src1, 32'h0);
    cmp("addi_src2", dif.src2, 32'h0);
    cmp("addi_imm", dif.imm, 32'hFFFFFFFA);
    cmp("addi_ctl", 32'(dif.control_in), 32'h10);
    cmp("addi_rd", 32'(dif.rd_out), 32'd5);

    // LW x6,8(x1) then dependent ADD x7,x6,x2
    set_in(LW6, 1, 0, 0, 5'd0, 32'h0); tick();
    cmp("lw_ctl", 32'(dif.control_in), 32'h20);
    cmp("lw_imm", dif.imm, 32'd8);
    cmp("lw_en", 32'(dif.enable_ex), 32'h1);
    set_in(ADD7, 1, 0, 0, 5'd0, 32'h0);
    chk_ready("hazard_ready", 0);
    tick();
    cmp("hazard_bubble", 32'(dif.enable_ex), 32'h0);
    set_in(ADD7, 1, 0, 1, 5'd6, 32'h55);
    chk_ready("post_hazard_ready", 1);
    tick();
    cmp("dep_en", 32'(dif.enable_ex), 32'h1);
    cmp("dep_src1", dif.src1, 32'h55);
    cmp("dep_src2", dif.src2, 32'd9);
    cmp("dep_rd", 32'(dif.rd_out), 32'd7);

    // Illegal word, then x0 write attempt
    set_in(32'hFFFFFFFF, 1, 0, 0, 5'd0, 32'h0); tick();
    cmp("ill_pulse", 32'(dif.illegal_instr), 32'h1);
    cmp("ill_en", 32'(dif.enable_ex), 32'h0);
    cmp("ill_ctl", 32'(dif.control_in), 32'h0);
    set_in(32'h0, 0, 0, 1, 5'd0, 32'h1234); tick();
    cmp("ill_once", 32'(dif.illegal_instr), 32'h0);
    set_in(ADD9, 1, 0, 1, 5'd0, 32'h1234); tick();
    cmp("x0_src1", dif.src1, 32'h0);
    cmp("x0_src2", dif.src2, 32'h0);
    cmp("x0_en", 32'(dif.enable_ex), 32'h1);

    // Stall hold for three cycles
    set_in(ADD3, 1, 0, 0, 5'd0, 32'h0); tick();
    set_in(ADDI5, 1, 1, 0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk_ready("stall_ready", 0);
      tick();
      cmp("stall_en", 32'(dif.enable_ex), 32'h1);
      cmp("stall_rd", 32'(dif.rd_out), 32'd3);
      cmp("stall_src2", dif.src2, 32'd9);
    end
    dif.ex_stall = 0;
    chk_ready("unstall_ready", 1);
    tick();
    cmp("unstall_rd", 32'(dif.rd_out), 32'd5);
    cmp("unstall_imm", dif.imm, 32'hFFFFFFFA);

    // Reset during a stall
    set_in(ADD3, 1, 0, 0, 5'd0, 32'h0); tick();
    set_in(ADDI5, 1, 1, 0, 5'd0, 32'h0); tick();
    rst_n = 1'b0;
    chk_ready("rst_ready", 0);
    tick();
    cmp("rst_en", 32'(dif.enable_ex), 32'h0);
    cmp("rst_src1", dif.src1, 32'h0);
    cmp("rst_src2", dif.src2, 32'h0);
    cmp("rst_rd", 32'(dif.rd_out), 32'h0);
    cmp("rst_ctl", 32'(dif.control_in), 32'h0);
    rst_n = 1'b1;
    set_in(ADDI5, 1, 0, 0, 5'd0, 32'h0); tick();
    cmp("after_rst_en", 32'(dif.enable_ex), 32'h1);
    cmp("after_rst_rd", 32'(dif.rd_out), 32'd5);
    cmp("after_rst_ctl", 32'(dif.control_in), 32'h10);

    // Random traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      set_in(rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    run_cmp = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
